// File: rtl/pipelined_carry_adder.sv
// Pipelined N-bit add/subtract built from S carry-registered slices of N/S bits,
// with valid/ready handshakes on both sides and a global stall from the output bank.
module pipelined_carry_adder #(
    parameter int unsigned N = 8,
    parameter int unsigned S = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    localparam int unsigned W = N / S;

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage k computes slice k. Operand bits not yet consumed move forward,
    // completed low sum bits grow by one slice per stage.
    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int unsigned IW = N - k * W;

        logic [IW-1:0]        op_a;
        logic [IW-1:0]        op_b;
        logic                 c_in;
        logic                 v_in;
        logic [W:0]           slice;
        logic [(k+1)*W-1:0]   sum_nx;
        logic [(k+1)*W-1:0]   sum_q;
        logic                 c_q;
        logic                 v_q;

        if (k == 0) begin : g_first
            // Subtract is a + ~b + ~cin.
            assign op_a   = a;
            assign op_b   = b ^ {N{sub}};
            assign c_in   = cin ^ sub;
            assign v_in   = in_valid & in_ready;
            assign sum_nx = slice[W-1:0];
        end else begin : g_next
            assign op_a   = g_stage[k-1].g_fwd.a_q;
            assign op_b   = g_stage[k-1].g_fwd.b_q;
            assign c_in   = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            assign sum_nx = {slice[W-1:0], g_stage[k-1].sum_q};
        end

        assign slice = {1'b0, op_a[W-1:0]} + {1'b0, op_b[W-1:0]} + {{W{1'b0}}, c_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q <= '0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
            end else if (!stall) begin
                sum_q <= sum_nx;
                c_q   <= slice[W];
                v_q   <= v_in;
            end
        end

        if (k < S - 1) begin : g_fwd
            logic [IW-W-1:0] a_q;
            logic [IW-W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= op_a[IW-1:W];
                    b_q <= op_b[IW-1:W];
                end
            end
        end

        if (k == S - 1) begin : g_last
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= op_a[W-1] ^ op_b[W-1] ^ slice[W-1] ^ slice[W];
                end
            end
        end
    end

    assign out_valid = g_stage[S-1].v_q;
    assign sum       = g_stage[S-1].sum_q;
    assign carry     = g_stage[S-1].c_q;
    assign overflow  = g_stage[S-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed checks of the N=8/S=2 adder plus a model-checked random sweep of
// N=16/S=4, N=8/S=1 and N=8/S=8 instances.
module tb_pipelined_carry_adder;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    typedef struct packed {
        logic [17:0] exp;
        int          stamp;
    } ent_t;

    int total = 0;
    int bad   = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, carry, overflow;
    logic [7:0] a, b, sum;

    logic [2:0]  iv, irdy, ci_s, sb_s, ov_s, ordy, oc, oof;
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [15:0] sum16;
    logic [7:0]  sum1, sum8;

    always #5 clk = ~clk;

    pipelined_carry_adder #(.N(8), .S(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .carry(carry), .overflow(overflow)
    );

    pipelined_carry_adder #(.N(16), .S(4)) u_n16s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a_s[0]),
        .b(b_s[0]), .cin(ci_s[0]), .sub(sb_s[0]), .out_valid(ov_s[0]), .out_ready(ordy[0]),
        .sum(sum16), .carry(oc[0]), .overflow(oof[0])
    );

    pipelined_carry_adder #(.N(8), .S(1)) u_n8s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a_s[1][7:0]),
        .b(b_s[1][7:0]), .cin(ci_s[1]), .sub(sb_s[1]), .out_valid(ov_s[1]),
        .out_ready(ordy[1]), .sum(sum1), .carry(oc[1]), .overflow(oof[1])
    );

    pipelined_carry_adder #(.N(8), .S(8)) u_n8s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a_s[2][7:0]),
        .b(b_s[2][7:0]), .cin(ci_s[2]), .sub(sb_s[2]), .out_valid(ov_s[2]),
        .out_ready(ordy[2]), .sum(sum8), .carry(oc[2]), .overflow(oof[2])
    );

    // Reference: full-width add of a and conditioned b, sign rule for overflow.
    function automatic logic [17:0] ref_op(int n, logic [15:0] x, logic [15:0] y,
                                           logic ci, logic sb);
        logic [16:0] mask, yy, full;
        logic [15:0] s;
        logic        co, ov;
        mask = (17'd1 << n) - 17'd1;
        yy   = (sb ? ~{1'b0, y} : {1'b0, y}) & mask;
        full = {1'b0, x} + yy + {16'd0, ci ^ sb};
        s    = full[15:0] & mask[15:0];
        co   = full[n];
        ov   = (x[n-1] == yy[n-1]) && (s[n-1] != x[n-1]);
        return {ov, co, s};
    endfunction

    task automatic put(input vec_t v);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out_valid, sum, carry, overflow, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h",
                     {out_valid, sum, carry, overflow, in_ready}, {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_held got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_add_stream();
        vec_t v [4];
        v[0] = '{8'h18, 8'h18, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
        v[1] = '{8'hAF, 8'hEE, 1'b0, 1'b0, 8'h9D, 1'b1, 1'b0};
        v[2] = '{8'h22, 8'h55, 1'b1, 1'b0, 8'h78, 1'b0, 1'b0};
        v[3] = '{8'h38, 8'hBB, 1'b1, 1'b0, 8'hF4, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) put(v[i]);
            else in_valid = 1'b0;
            @(posedge clk); #1;
            total++;
            if (i == 0) begin
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL add_latency got=%b exp=0", out_valid);
                end
            end else if ({out_valid, sum, carry, overflow} !==
                         {1'b1, v[i-1].s, v[i-1].c, v[i-1].o}) begin
                bad++;
                $display("FAIL add_%0d got=%h exp=%h", i - 1, {out_valid, sum, carry, overflow},
                         {1'b1, v[i-1].s, v[i-1].c, v[i-1].o});
            end
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_subtract();
        vec_t v [3];
        v[0] = '{8'h50, 8'h30, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0};
        v[1] = '{8'h30, 8'h50, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b0};
        v[2] = '{8'h50, 8'h30, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) put(v[i]);
            else in_valid = 1'b0;
            @(posedge clk); #1;
            if (i > 0) begin
                total++;
                if ({out_valid, sum, carry, overflow} !== {1'b1, v[i-1].s, v[i-1].c, v[i-1].o}) begin
                    bad++;
                    $display("FAIL sub_%0d got=%h exp=%h", i - 1, {out_valid, sum, carry, overflow},
                             {1'b1, v[i-1].s, v[i-1].c, v[i-1].o});
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        vec_t v [3];
        v[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        v[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        v[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) put(v[i]);
            else in_valid = 1'b0;
            @(posedge clk); #1;
            if (i > 0) begin
                total++;
                if ({out_valid, sum, carry, overflow} !== {1'b1, v[i-1].s, v[i-1].c, v[i-1].o}) begin
                    bad++;
                    $display("FAIL ovf_%0d got=%h exp=%h", i - 1, {out_valid, sum, carry, overflow},
                             {1'b1, v[i-1].s, v[i-1].c, v[i-1].o});
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        vec_t        v [4];
        int          sent, rcv, hold;
        logic [10:0] prev;
        v[0] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
        v[1] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
        v[2] = '{8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0};
        v[3] = '{8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1};
        sent = 0;
        rcv  = 0;
        hold = 0;
        prev = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (sent < 4) put(v[sent]);
            else in_valid = 1'b0;
            out_ready = !(out_valid && hold < 3);
            #1;
            if (!out_ready) begin
                hold++;
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready got=%b exp=0", in_ready);
                end
                if (hold > 1) begin
                    total++;
                    if ({out_valid, sum, carry, overflow} !== prev) begin
                        bad++;
                        $display("FAIL bp_frozen got=%h exp=%h",
                                 {out_valid, sum, carry, overflow}, prev);
                    end
                end
            end
            prev = {out_valid, sum, carry, overflow};
            if (out_valid && out_ready) begin
                total++;
                if (rcv >= 4) begin
                    bad++;
                    $display("FAIL bp_extra got=%h exp=none", {sum, carry, overflow});
                end else if ({sum, carry, overflow} !== {v[rcv].s, v[rcv].c, v[rcv].o}) begin
                    bad++;
                    $display("FAIL bp_order_%0d got=%h exp=%h", rcv, {sum, carry, overflow},
                             {v[rcv].s, v[rcv].c, v[rcv].o});
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        total++;
        if (rcv != 4 || sent != 4 || hold != 3) begin
            bad++;
            $display("FAIL bp_count got=%0d/%0d/%0d exp=4/4/3", sent, rcv, hold);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        put('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        @(posedge clk); #1;
        put('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        total++;
        if ({out_valid, sum, carry, overflow, in_ready} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL rst_pre got=%h exp=%h", {out_valid, sum, carry, overflow, in_ready},
                     {1'b1, 8'h80, 1'b0, 1'b1, 1'b0});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, sum, carry, overflow, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_async got=%h exp=%h", {out_valid, sum, carry, overflow, in_ready},
                     {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_ghost cyc=%0d got=%b exp=0", i, out_valid);
            end
        end
    endtask

    task automatic test_sweep();
        ent_t        q0 [$];
        ent_t        q1 [$];
        ent_t        q2 [$];
        ent_t        e;
        logic [17:0] got;
        logic [15:0] osum, mask;
        int          n, s;
        bit          has;
        for (int cyc = 0; cyc < 2060; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                mask    = (i == 0) ? 16'hFFFF : 16'h00FF;
                iv[i]   = (cyc < 2030) && (cyc < 30 || $urandom_range(0, 3) != 0);
                ordy[i] = (cyc < 30 || cyc >= 2030 || $urandom_range(0, 3) != 0);
                a_s[i]  = 16'($urandom) & mask;
                b_s[i]  = 16'($urandom) & mask;
                ci_s[i] = 1'($urandom);
                sb_s[i] = 1'($urandom);
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                n = (i == 0) ? 16 : 8;
                s = (i == 0) ? 4 : ((i == 1) ? 1 : 8);
                case (i)
                    0:       osum = sum16;
                    1:       osum = {8'h00, sum1};
                    default: osum = {8'h00, sum8};
                endcase
                got = {oof[i], oc[i], osum};
                if (ov_s[i] && ordy[i]) begin
                    has = 1'b0;
                    case (i)
                        0:       if (q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
                        1:       if (q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); has = 1'b1; end
                    endcase
                    total++;
                    if (!has) begin
                        bad++;
                        $display("FAIL sweep_extra dut=%0d got=%h exp=none", i, got);
                    end else begin
                        if (got !== e.exp) begin
                            bad++;
                            $display("FAIL sweep_data dut=%0d cyc=%0d got=%h exp=%h",
                                     i, cyc, got, e.exp);
                        end
                        if (cyc < 30) begin
                            total++;
                            if (cyc - e.stamp != s) begin
                                bad++;
                                $display("FAIL sweep_latency dut=%0d got=%0d exp=%0d",
                                         i, cyc - e.stamp, s);
                            end
                        end
                    end
                end
                if (iv[i] && irdy[i]) begin
                    e.exp   = ref_op(n, a_s[i], b_s[i], ci_s[i], sb_s[i]);
                    e.stamp = cyc;
                    case (i)
                        0:       q0.push_back(e);
                        1:       q1.push_back(e);
                        default: q2.push_back(e);
                    endcase
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0 || ov_s !== 3'b000) begin
            bad++;
            $display("FAIL sweep_drain got=%0d/%0d/%0d/%b exp=0/0/0/000",
                     q0.size(), q1.size(), q2.size(), ov_s);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        iv        = '0;
        ordy      = '1;
        ci_s      = '0;
        sb_s      = '0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_add_stream();
        test_subtract();
        test_overflow();
        test_back_pressure();
        test_reset_midstream();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_adder.md
# pipelined_carry_adder

Parametrised, pipelined successor to the N-bit ripple-carry adder. Splits an N-bit add/subtract into S carry-registered slices of N/S bits, accepting one operation per cycle with a valid/ready handshake on both sides. Adds a subtract mode, signed-overflow flag and back-pressure. Sits between operand producers and result consumers in the arithmetic datapath where a full N-bit ripple does not close timing.

## Interface
- N, 8, operand/result width in bits; N ≥ 2
- S, 2, pipeline stages = carry slices; N % S == 0, 1 ≤ S ≤ N; slice width W = N/S
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept this cycle
- a  in  N  operand A, unsigned/two's complement
- b  in  N  operand B
- cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0: a+b+cin; 1: a−b−cin
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result this cycle
- sum  out  N  result, mod 2^N
- carry  out  1  carry-out; in sub mode 1 = no borrow
- overflow  out  1  signed two's-complement overflow

## Operation
- Operand conditioning at acceptance: b' = b ^ {N{sub}}, c0 = cin ^ sub; so sub computes a + ~b + ~cin = a − b − cin (mod 2^N).
- Slice k (0..S−1) adds bits [k·W +: W] of a and b' plus incoming carry; carry-out registered into slice k+1's stage.
- Skew: slice k operands delayed k stages; completed low slices delayed (S−1−k) stages so all N sum bits align at the output bank.
- carry = carry-out of slice S−1; overflow = carry into bit N−1 XOR carry out of bit N−1.
- Each stage holds a valid bit; data moves with its valid bit, no reordering, no compaction of bubbles.
- Stall: stall = out_valid & ~out_ready. While stall, every stage register (data, carries, valids) holds. in_ready = ~stall.
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- in_valid while in_ready low: operands not sampled; producer holds them.
- Unaccepted cycles insert a bubble (valid 0) into stage 0.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, all data/carry registers 0 → out_valid=0, sum=0, carry=0, overflow=0, in_ready=1. Held throughout reset; takes effect without a clock edge.
- Reset mid-operation: all in-flight operations discarded; none emerge after release.
- First edge after rst_n rises may accept.
- Latency: operation accepted at edge E appears on sum/carry/overflow with out_valid=1 after edge E+S−1 (S edges counting E), provided no stall. S=1 → registered after acceptance edge.
- Throughput: one operation per cycle with out_ready held high.
- Outputs registered; stable while out_valid & ~out_ready.
- Simultaneous output transfer and input acceptance in the same cycle is normal flow.
- in_ready depends combinationally on out_valid (registered) and out_ready only; no path from in_valid.
- Wrap-around: sum discards bit N; carry reports it.

## Test plan
- Reset: rst_n low mid-stream with 2 ops in flight → out_valid drops to 0 immediately; sum=0, carry=0, overflow=0; in_ready=1; no result appears after release.
- Add stream (N=8, S=2), out_ready=1, back-to-back: 18+18 cin=1 → 31/c0; AF+EE cin=0 → 9D/c1/ov0; 22+55 cin=1 → 78/c0; 38+BB cin=1 → F4/c0. Results on consecutive cycles, first at 2 cycles latency.
- Subtract: 50−30 cin=0 sub=1 → 20, carry=1; 30−50 → E0, carry=0; 50−30 cin=1 → 1F, carry=1.
- Overflow: 7F+01 → 80, ov=1, c=0; 80−01 sub → 7F, ov=1, c=1; FF+01 → 00, ov=0, c=1.
- Back-pressure: 4 back-to-back ops, out_ready low 3 cycles once first result valid → outputs frozen, in_ready=0, no loss/duplication, order preserved after release.
- Parameter sweep: N=16/S=4, N=8/S=1, N=8/S=8 with 1000 random ops and random in_valid/out_ready → all match reference model, latency exactly S without stalls.
